// File: rtl/wash_sequencer_if.sv
// Control bundle between the wash sequencer, its phase timer and the actuators.
// master drives commands and timer status; slave is the sequencer itself.
interface wash_sequencer_if;
  logic       start;
  logic       double_wash;
  logic       pause;
  logic       door_closed;
  logic       tmr_done;
  logic       tmr_clear;
  logic       tmr_enable;
  logic [3:0] tmr_period;
  logic       door_lock;
  logic       water_valve;
  logic       motor_on;
  logic       motor_fast;
  logic       drain_pump;
  logic       finished;
  logic [2:0] state_code;

  modport master (
    output start, double_wash, pause, door_closed, tmr_done,
    input  tmr_clear, tmr_enable, tmr_period, door_lock, water_valve,
           motor_on, motor_fast, drain_pump, finished, state_code
  );

  modport slave (
    input  start, double_wash, pause, door_closed, tmr_done,
    output tmr_clear, tmr_enable, tmr_period, door_lock, water_valve,
           motor_on, motor_fast, drain_pump, finished, state_code
  );
endinterface

// File: rtl/wash_sequencer.sv
// Wash program controller: FILL -> WASH -> RINSE (-> WASH -> RINSE) -> SPIN -> DONE,
// loading each phase duration into the external timer; outputs decode registers only.
module wash_sequencer #(
  parameter logic [3:0] FILL_T  = 4'd2,
  parameter logic [3:0] WASH_T  = 4'd5,
  parameter logic [3:0] RINSE_T = 4'd2,
  parameter logic [3:0] SPIN_T  = 4'd1
) (
  input  logic            clk,
  input  logic            reset,
  wash_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WASH  = 3'd2,
    S_RINSE = 3'd3,
    S_SPIN  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_dbl;
  logic       r_pass2;
  logic       r_paused;
  logic       r_first;
  logic       w_active;
  logic       w_enable;
  logic       w_phase_done;
  logic [3:0] w_period;

  assign w_active     = (r_state == S_FILL) || (r_state == S_WASH) ||
                        (r_state == S_RINSE) || (r_state == S_SPIN);
  assign w_enable     = w_active && !r_first && !r_paused;
  // Done is only honoured once the entry cycle has cleared the timer.
  assign w_phase_done = bus.tmr_done && w_enable;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start && bus.door_closed) w_next = S_FILL;
      S_FILL:  if (w_phase_done) w_next = S_WASH;
      S_WASH:  if (w_phase_done) w_next = S_RINSE;
      S_RINSE: if (w_phase_done) w_next = (r_dbl && !r_pass2) ? S_WASH : S_SPIN;
      S_SPIN:  if (w_phase_done) w_next = S_DONE;
      S_DONE:  if (!bus.door_closed) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_dbl    <= 1'b0;
      r_pass2  <= 1'b0;
      r_paused <= 1'b0;
      r_first  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_first <= (w_next != r_state) &&
                 ((w_next == S_FILL) || (w_next == S_WASH) ||
                  (w_next == S_RINSE) || (w_next == S_SPIN));
      // Qualified by the next state so SPIN and DONE never inherit a pause.
      r_paused <= ((w_next == S_FILL) || (w_next == S_WASH) || (w_next == S_RINSE)) &&
                  (bus.pause || !bus.door_closed);
      if ((r_state == S_IDLE) && (w_next == S_FILL)) begin
        r_dbl   <= bus.double_wash;
        r_pass2 <= 1'b0;
      end else if ((r_state == S_RINSE) && (w_next == S_WASH)) begin
        r_pass2 <= 1'b1;
      end
    end
  end

  always_comb begin
    w_period = 4'd0;
    case (r_state)
      S_FILL:  w_period = FILL_T;
      S_WASH:  w_period = WASH_T;
      S_RINSE: w_period = RINSE_T;
      S_SPIN:  w_period = SPIN_T;
      default: w_period = 4'd0;
    endcase
  end

  assign bus.tmr_clear   = r_first;
  assign bus.tmr_enable  = w_enable;
  assign bus.tmr_period  = w_period;
  assign bus.door_lock   = w_active;
  assign bus.water_valve = (r_state == S_FILL) && !r_paused;
  assign bus.motor_on    = ((r_state == S_WASH) || (r_state == S_RINSE) ||
                            (r_state == S_SPIN)) && !r_paused;
  assign bus.motor_fast  = (r_state == S_SPIN);
  assign bus.drain_pump  = ((r_state == S_RINSE) || (r_state == S_SPIN)) && !r_paused;
  assign bus.finished    = (r_state == S_DONE);
  assign bus.state_code  = r_state;
endmodule

// File: tb/tb_wash_sequencer.sv
// Directed bench for wash_sequencer with a behavioural phase timer and a stub done override.
module tb_wash_sequencer;
  logic clk;
  logic reset;
  wash_sequencer_if ifc();

  wash_sequencer dut (.clk(clk), .reset(reset), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timer model: done after period+1 enabled edges, sticky until cleared.
  logic [4:0] t_cnt;
  logic       t_done;
  logic       stub_hold;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      t_cnt  <= 5'd0;
      t_done <= 1'b0;
    end else if (ifc.tmr_clear) begin
      t_cnt  <= 5'd0;
      t_done <= 1'b0;
    end else if (ifc.tmr_enable && !t_done) begin
      if (t_cnt == {1'b0, ifc.tmr_period}) t_done <= 1'b1;
      else t_cnt <= t_cnt + 5'd1;
    end
  end
  assign ifc.tmr_done = t_done | stub_hold;

  int n_assert;
  int n_fail;
  int clr_cnt;
  int total;
  int len;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] out_vec();
    return {ifc.tmr_clear, ifc.tmr_enable, ifc.tmr_period, ifc.door_lock,
            ifc.water_valve, ifc.motor_on, ifc.motor_fast, ifc.drain_pump,
            ifc.finished, ifc.state_code};
  endfunction

  // Counts cycles spent in phase `code`, starting from cycle number start_len.
  task automatic run_rest(input logic [2:0] code, input int start_len, output int n);
    int guard;
    n = start_len - 1;
    guard = 0;
    while (ifc.state_code == code && guard < 200) begin
      if (ifc.tmr_clear) clr_cnt++;
      tick();
      n++;
      guard++;
    end
  endtask

  task automatic phase(input string tag, input logic [2:0] code,
                       input logic [3:0] per, input int exp_len);
    int n;
    chk({tag, "_state"}, ifc.state_code, code);
    chk({tag, "_clear"}, ifc.tmr_clear, 1'b1);
    chk({tag, "_period"}, ifc.tmr_period, per);
    run_rest(code, 1, n);
    chk({tag, "_len"}, n, exp_len);
    total += n;
  endtask

  task automatic start_prog(input logic dbl);
    ifc.double_wash = dbl;
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
  endtask

  initial begin
    n_assert = 0; n_fail = 0; clr_cnt = 0; total = 0; len = 0;
    stub_hold = 1'b0;
    reset = 1'b1;
    ifc.start = 1'b0; ifc.double_wash = 1'b0; ifc.pause = 1'b0; ifc.door_closed = 1'b1;
    #3;
    chk("reset_outputs", out_vec(), 15'd0);
    #20;
    reset = 1'b0;
    tick();

    // Start with door open is ignored.
    ifc.door_closed = 1'b0;
    start_prog(1'b0);
    chk("door_open_start", ifc.state_code, 3'd0);
    tick();
    chk("door_open_idle", ifc.state_code, 3'd0);
    ifc.door_closed = 1'b1;

    // Single program.
    start_prog(1'b0);
    chk("fill_valve", ifc.water_valve, 1'b1);
    chk("fill_lock", ifc.door_lock, 1'b1);
    chk("fill_entry_en", ifc.tmr_enable, 1'b0);
    total = 0;
    phase("s_fill", 3'd1, 4'd2, 5);
    chk("wash_motor", ifc.motor_on, 1'b1);
    phase("s_wash", 3'd2, 4'd5, 8);
    chk("rinse_drain", ifc.drain_pump, 1'b1);
    phase("s_rinse", 3'd3, 4'd2, 5);
    chk("spin_fast", ifc.motor_fast, 1'b1);
    phase("s_spin", 3'd4, 4'd1, 4);
    chk("s_total", total, 22);
    chk("s_done_state", ifc.state_code, 3'd5);
    chk("s_finished", ifc.finished, 1'b1);
    chk("s_done_unlock", ifc.door_lock, 1'b0);
    tick();
    chk("s_done_hold", ifc.state_code, 3'd5);
    ifc.door_closed = 1'b0;
    tick();
    chk("s_done_to_idle", ifc.state_code, 3'd0);
    ifc.door_closed = 1'b1;
    tick();

    // Double wash.
    start_prog(1'b1);
    total = 0; clr_cnt = 0;
    phase("d_fill", 3'd1, 4'd2, 5);
    phase("d_wash1", 3'd2, 4'd5, 8);
    phase("d_rinse1", 3'd3, 4'd2, 5);
    phase("d_wash2", 3'd2, 4'd5, 8);
    phase("d_rinse2", 3'd3, 4'd2, 5);
    phase("d_spin", 3'd4, 4'd1, 4);
    chk("d_total", total, 35);
    chk("d_clear_pulses", clr_cnt, 6);
    chk("d_done", ifc.state_code, 3'd5);
    ifc.door_closed = 1'b0;
    tick();
    ifc.door_closed = 1'b1;
    tick();

    // Pause in WASH, door open in RINSE and SPIN.
    start_prog(1'b0);
    phase("p_fill", 3'd1, 4'd2, 5);
    chk("p_wash_entry", ifc.state_code, 3'd2);
    tick();
    ifc.pause = 1'b1;
    tick();
    chk("p_motor_off", ifc.motor_on, 1'b0);
    chk("p_enable_off", ifc.tmr_enable, 1'b0);
    chk("p_lock_held", ifc.door_lock, 1'b1);
    tick();
    tick();
    chk("p_still_paused", ifc.motor_on, 1'b0);
    tick();
    ifc.pause = 1'b0;
    run_rest(3'd2, 6, len);
    chk("p_wash_len", len, 12);
    chk("p_rinse_entry", ifc.state_code, 3'd3);
    tick();
    ifc.door_closed = 1'b0;
    tick();
    chk("p_rinse_door_motor", ifc.motor_on, 1'b0);
    chk("p_rinse_door_drain", ifc.drain_pump, 1'b0);
    chk("p_rinse_door_en", ifc.tmr_enable, 1'b0);
    tick();
    ifc.door_closed = 1'b1;
    run_rest(3'd3, 4, len);
    chk("p_rinse_len", len, 7);
    chk("p_spin_entry", ifc.state_code, 3'd4);
    tick();
    ifc.door_closed = 1'b0;
    tick();
    chk("p_spin_door_motor", ifc.motor_on, 1'b1);
    chk("p_spin_door_en", ifc.tmr_enable, 1'b1);
    run_rest(3'd4, 3, len);
    chk("p_spin_len", len, 4);
    chk("p_done", ifc.finished, 1'b1);
    tick();
    chk("p_done_open_idle", ifc.state_code, 3'd0);
    ifc.door_closed = 1'b1;
    tick();

    // Stale done held across phase entries must not skip a phase.
    stub_hold = 1'b1;
    start_prog(1'b0);
    phase("st_fill", 3'd1, 4'd2, 2);
    phase("st_wash", 3'd2, 4'd5, 2);
    stub_hold = 1'b0;
    phase("st_rinse", 3'd3, 4'd2, 5);
    phase("st_spin", 3'd4, 4'd1, 4);
    ifc.door_closed = 1'b0;
    tick();
    ifc.door_closed = 1'b1;
    tick();

    // Async reset mid-SPIN, then a full program.
    start_prog(1'b0);
    phase("r_fill", 3'd1, 4'd2, 5);
    phase("r_wash", 3'd2, 4'd5, 8);
    phase("r_rinse", 3'd3, 4'd2, 5);
    chk("r_spin", ifc.state_code, 3'd4);
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("r_async_outputs", out_vec(), 15'd0);
    #2;
    reset = 1'b0;
    tick();
    chk("r_idle_after", ifc.state_code, 3'd0);
    start_prog(1'b0);
    phase("r2_fill", 3'd1, 4'd2, 5);
    phase("r2_wash", 3'd2, 4'd5, 8);
    phase("r2_rinse", 3'd3, 4'd2, 5);
    phase("r2_spin", 3'd4, 4'd1, 4);
    chk("r2_done", ifc.state_code, 3'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/wash_sequencer.md
# wash_sequencer

Cycle controller for the washing machine, directly downstream of the `timer` block.

- It steps through the wash program FILL → WASH → RINSE → (optional second WASH/RINSE) → SPIN.
- For each phase it loads the phase duration into the timer, restarts it, and advances when the timer reports completion.
- It drives the valve, motor, pump and door-lock actuators and supports pause and door-open safety.

## Interface
Parameters:
- FILL_T, 4'd2, fill duration passed to the timer as timer_period
- WASH_T, 4'd5, wash duration
- RINSE_T, 4'd2, rinse duration
- SPIN_T, 4'd1, spin duration

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high; clock clk
- start  input  1  request to begin a program; sampled in IDLE only
- double_wash  input  1  selects two wash/rinse passes; latched when start is accepted
- pause  input  1  level; freezes FILL/WASH/RINSE while high
- door_closed  input  1  level; 1 = door shut
- tmr_done  input  1  timer completion flag (sticky until timer reset)
- tmr_clear  output  1  drives the timer's reset; one-cycle pulse at each phase entry
- tmr_enable  output  1  timer count enable
- tmr_period  output  4  current phase duration
- door_lock  output  1  door locked
- water_valve  output  1  inlet valve open
- motor_on  output  1  drum motor running
- motor_fast  output  1  high-speed spin
- drain_pump  output  1  drain pump on
- finished  output  1  program complete
- state_code  output  3  IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4, DONE=5

## Operation
- State register with states IDLE, FILL, WASH, RINSE, SPIN, DONE. Registered flags:
  - dbl (latched double_wash)
  - pass2 (second pass in progress)
  - paused
  - first (phase-entry cycle)
- Transitions:
  - IDLE → FILL when start=1 and door_closed=1; dbl ← double_wash, pass2 ← 0. start with the door open is ignored.
  - FILL → WASH on phase done.
  - WASH → RINSE on phase done.
  - RINSE → WASH on phase done if dbl=1 and pass2=0; pass2 ← 1.
  - RINSE → SPIN on phase done otherwise.
  - SPIN → DONE on phase done.
  - DONE → IDLE when door_closed=0.
- Phase done = tmr_done=1 while tmr_enable=1 and first=0. tmr_done is ignored in the entry cycle, so a stale done from the previous phase is never consumed.
- Every transition into FILL/WASH/RINSE/SPIN, including RINSE→WASH, sets first=1 for exactly one cycle.
  - During that cycle: tmr_clear=1, tmr_enable=0.
- tmr_period is decoded from the state: FILL_T, WASH_T, RINSE_T, SPIN_T. It is 0 in IDLE/DONE.
- paused ← (pause | ~door_closed) in FILL/WASH/RINSE, updated every cycle; forced 0 in other states.
- SPIN cannot be paused. A door-open during SPIN does not change SPIN behaviour.
- tmr_enable = 1 in FILL/WASH/RINSE/SPIN when first=0 and paused=0; 0 otherwise. While paused the timer count freezes and resumes from the same value.
- Actuators are decoded from state and paused only, with no combinational input-to-output path:
  - water_valve = FILL & ~paused
  - motor_on = (WASH|RINSE|SPIN) & ~paused
  - motor_fast = SPIN
  - drain_pump = (RINSE|SPIN) & ~paused
  - door_lock = FILL|WASH|RINSE|SPIN (held through pause)
  - finished = DONE
- Widths: all periods are 4-bit, passed through unmodified. A period of 0 is legal, and the timer then finishes after 1 enabled edge.

## Timing
- Reset (async) values:
  - state=IDLE, dbl=0, pass2=0, paused=0, first=0
  - all outputs 0, state_code=0
- Start latency: start sampled high at edge E0 → state=FILL, tmr_clear=1 in the cycle after E0.
- Phase length: with the team timer at clk_freq=1 and period P, a phase lasts P+3 cycles:
  - 1 clear cycle
  - P+1 enabled edges to done
  - 1 cycle to advance
- Each cycle of pause adds one cycle to the phase. Pause takes effect one edge after the input rises (paused is registered).
- Simultaneous events:
  - If pause rises in the same cycle tmr_done is seen with enable=1, the transition still occurs.
  - start in any non-IDLE state is ignored.
- Reset mid-phase returns everything to reset values immediately. The timer is reset externally by the same reset.

## Test plan
- Single program, clk_freq=1, defaults, double_wash=0, start pulse at edge 0 → FILL 5 cycles, WASH 8, RINSE 5, SPIN 4. state_code=5 and finished=1 at cycle 23, door_lock=0 there.
- double_wash=1 → sequence 1,2,3,2,3,4,5. Total FILL-to-DONE time is 35 cycles. tmr_clear pulses exactly 6 times.
- pause held 4 cycles mid-WASH → motor_on=0 and tmr_enable=0 for those cycles, door_lock stays 1, WASH lasts 12 cycles.
- start with door_closed=0 → remains IDLE. Later, door opens during RINSE → behaves as pause. Door open during SPIN → no effect. Door opens in DONE → IDLE next edge.
- Stale-done check: stub timer holding tmr_done=1 across a phase entry → no phase skip; the entry cycle is ignored and the phase advances only after the clear.
- Async reset asserted mid-SPIN, between clock edges → all outputs 0 and state_code=0 immediately. The next start runs a full program.
